// File: rtl/tage_update_queue.sv
// tage_update_queue
//   Commit-side producer for the TAGE update port. Resolved branch-block
//   updates from backend commit are buffered in a circular FIFO and issued
//   to the predictor as single-cycle update pulses, at most one per cycle.
//   Issue stalls while tage_ready is low, so no update is ever lost.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-low
//   clear          synchronous discard of all pending entries
//   in_valid       commit presents an update
//   in_ready       queue can accept (not full)
//   in_start_addr  block start address
//   in_real_taken  resolved direction per slot
//   in_alloc_slot  slot eligible for alloc/update
//   in_meta        TAGE meta captured at predict time (opaque)
//   tage_ready     predictor can take an update this cycle
//   out_update     one-cycle update strobe
//   out_start_addr registered start address, valid with out_update
//   out_real_taken registered directions, valid with out_update
//   out_alloc_slot registered alloc slots, valid with out_update
//   out_meta       registered meta, valid with out_update
//   count          current occupancy (0..DEPTH)
module tage_update_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int SLOTS  = 2,
    parameter int META_W = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_start_addr,
    input  logic [SLOTS-1:0]           in_real_taken,
    input  logic [SLOTS-1:0]           in_alloc_slot,
    input  logic [META_W-1:0]          in_meta,
    input  logic                       tage_ready,
    output logic                       out_update,
    output logic [ADDR_W-1:0]          out_start_addr,
    output logic [SLOTS-1:0]           out_real_taken,
    output logic [SLOTS-1:0]           out_alloc_slot,
    output logic [META_W-1:0]          out_meta,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [SLOTS-1:0]  mem_taken [DEPTH];
    logic [SLOTS-1:0]  mem_alloc [DEPTH];
    logic [META_W-1:0] mem_meta  [DEPTH];

    // Pointers carry one extra wrap bit above the index bits.
    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign count    = tail - head;

    // in_ready depends on stored state only; a dequeue in the same cycle
    // does not open a slot until the next cycle.
    assign in_ready = ~full;
    assign enq      = in_valid & ~full & ~clear;
    assign deq      = ~empty & tage_ready & ~clear;

    // Payload storage needs no reset: occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[tail_idx]  <= in_start_addr;
            mem_taken[tail_idx] <= in_real_taken;
            mem_alloc[tail_idx] <= in_alloc_slot;
            mem_meta[tail_idx]  <= in_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head           <= '0;
            tail           <= '0;
            out_update     <= 1'b0;
            out_start_addr <= '0;
            out_real_taken <= '0;
            out_alloc_slot <= '0;
            out_meta       <= '0;
        end else begin
            out_update <= deq;
            if (clear) begin
                head <= tail;
            end else begin
                if (enq) begin
                    tail <= tail + PTR_ONE;
                end
                if (deq) begin
                    head           <= head + PTR_ONE;
                    out_start_addr <= mem_addr[head_idx];
                    out_real_taken <= mem_taken[head_idx];
                    out_alloc_slot <= mem_alloc[head_idx];
                    out_meta       <= mem_meta[head_idx];
                end
            end
        end
    end

endmodule
